// File: rtl/if_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package if_pkg;

  localparam int XLEN = 32;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } if_state_e;

  // J-type immediate from instruction bits [31:12], sign-extended to XLEN.
  function automatic logic signed [XLEN-1:0] jal_imm(input logic [19:0] jfield);
    logic signed [XLEN-1:0] imm;
    imm = {{11{jfield[19]}}, jfield[19], jfield[7:0], jfield[8], jfield[18:9], 1'b0};
    return imm;
  endfunction

  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Show-ahead fetch queue with synchronous flush; head entry is readable
// combinationally whenever the queue is non-empty.
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty && !flush;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push   = push && !flush && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch buffer: one outstanding memory fetch feeding a show-ahead queue.
// Optional macro IF_JAL_PREDECODE_EN enables JAL predecode and predicted-taken redirection.
module instruction_prefetch_buffer
  import if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_pred_taken
);

  localparam int WIDTH = 2 * XLEN + 1;

  if_state_e        state, state_nxt;
  logic [XLEN-1:0]  fetch_pc, fetch_pc_nxt, next_pc;
  logic             pred_taken;
  logic             push, pop, fifo_empty, fifo_full;
  logic [WIDTH-1:0] push_data, head_data;

`ifdef IF_JAL_PREDECODE_EN
  assign pred_taken = (imem_rdata[6:0] == OPC_JAL);
  assign next_pc    = pred_taken ? align4(fetch_pc + jal_imm(imem_rdata[31:12]))
                                 : fetch_pc + 32'd4;
`else
  assign pred_taken = 1'b0;
  assign next_pc    = fetch_pc + 32'd4;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = '0;
    case (state)
      IDLE: begin
        if (!redirect && !fifo_full) state_nxt = REQ;
      end
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = align4(fetch_pc);
        if (redirect)      state_nxt = imem_gnt ? DRAIN : IDLE;
        else if (imem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        // A response landing with a redirect answers the dropped request; nothing left to drain.
        if (redirect) begin
          state_nxt = imem_rvalid ? IDLE : DRAIN;
        end else if (imem_rvalid) begin
          state_nxt    = IDLE;
          push         = 1'b1;
          fetch_pc_nxt = next_pc;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect) fetch_pc_nxt = align4(redirect_pc);
  end

  assign push_data = {pred_taken, fetch_pc, imem_rdata};
  assign pop       = !fifo_empty && out_ready && !redirect;

  if_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head_data(head_data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = out_valid ? head_data[2*XLEN-1:XLEN] : '0;
  assign out_instr = out_valid ? head_data[XLEN-1:0] : '0;

`ifdef IF_JAL_PREDECODE_EN
  assign out_pred_taken = out_valid & head_data[WIDTH-1];
`else
  logic unused_pred;
  assign unused_pred    = head_data[WIDTH-1];
  assign out_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Bench for instruction_prefetch_buffer: memory responder plus queue-based reference model.
module tb_instruction_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset, redirect, imem_req, imem_gnt, imem_rvalid;
  logic        out_valid, out_ready, out_pred_taken;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, out_pc, out_instr;

  always #5 clk = ~clk;

  instruction_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_pred_taken(out_pred_taken)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } entry_t;

  entry_t      exp_q[$];
  entry_t      pop_log[$];
  logic [31:0] grant_log[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_pc, pend_addr;
  bit          pending, stale, inject, jal_test, gnt_rand;
  int          lat, lat_min, lat_max, grants, n;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jal_test && a == 32'h8) return 32'h010000EF;  // jal ra, +16
    return ((a * 32'h9E3779B1) & 32'hFFFF_FF80) | 32'h13;
  endfunction

  function automatic logic [31:0] jimm(input logic [31:0] i);
    logic signed [20:0] v;
    v = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    return 32'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory, check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit          resp, hs, pop_now;
    logic [31:0] req_addr;
    entry_t      e;
    imem_gnt    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    resp        = (pending && lat == 0) || inject;
    imem_rvalid = resp;
    imem_rdata  = !resp ? 32'h0 : (inject ? 32'hDEAD_BEEF : mem_word(pend_addr));
    #1;
    check("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
    check("single_outstanding", imem_req && pending, 0);
    if (imem_req) check("imem_addr", imem_addr, model_pc);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (out_valid && exp_q.size() != 0) begin
      check("out_pc", out_pc, exp_q[0].pc);
      check("out_instr", out_instr, exp_q[0].instr);
      check("out_pred_taken", out_pred_taken, exp_q[0].pred);
    end
    hs       = imem_req && imem_gnt;
    req_addr = imem_addr;
    pop_now  = out_valid && out_ready && !redirect;
    @(posedge clk);
    if (redirect) begin
      exp_q.delete();
      model_pc = redirect_pc & ~32'h3;
      stale    = 1'b1;
    end else if (pop_now && exp_q.size() != 0) begin
      pop_log.push_back(exp_q.pop_front());
    end
    if (resp && pending) begin
      if (!stale) begin
        e.pc     = model_pc;
        e.instr  = mem_word(pend_addr);
        e.pred   = 1'b0;
        model_pc = model_pc + 32'd4;
`ifdef IF_JAL_PREDECODE_EN
        if (e.instr[6:0] == 7'b1101111) begin
          e.pred   = 1'b1;
          model_pc = (e.pc + jimm(e.instr)) & ~32'h3;
        end
`endif
        exp_q.push_back(e);
      end
      pending = 1'b0;
    end else if (pending) begin
      lat--;
    end
    if (hs) begin
      pending   = 1'b1;
      stale     = redirect;
      pend_addr = req_addr;
      lat       = $urandom_range(lat_min, lat_max);
      grants++;
      grant_log.push_back(req_addr);
    end
    inject = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_imem_req", imem_req, 0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_pred", out_pred_taken, 0);
      @(negedge clk);
    end
    reset = 1'b0;
    model_pc = 32'h0; exp_q.delete(); pop_log.delete(); grant_log.delete();
    pending = 1'b0; stale = 1'b0; grants = 0; inject = 1'b1;  // stale pre-reset response
  endtask

  task automatic wait_req(input int max_cycles);
    int k = 0;
    while (!imem_req && k < max_cycles) begin cycle(); k++; end
    check("wait_req_timeout", imem_req, 1);
  endtask

  initial begin
    logic [31:0] exp_next;
    logic        exp_pred;
    jal_test = 0; gnt_rand = 0; lat_min = 0; lat_max = 0;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);

    // Sequential streaming, 1-cycle memory, decode always ready.
    do_reset();
    out_ready = 1'b1;
    repeat (25) cycle();
    check("seq_count", pop_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < pop_log.size(); i++) begin
      check("seq_pc", pop_log[i].pc, 32'(i * 4));
      check("seq_instr", pop_log[i].instr, mem_word(32'(i * 4)));
    end

    // Decode stalled: fetch stops once four entries are queued.
    do_reset();
    repeat (30) cycle();
    check("stall_grants", grants, 4);
    check("stall_req_idle", imem_req, 0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    repeat (15) cycle();
    check("one_more_grant", grants, 5);
    check("stall_req_idle2", imem_req, 0);
    // Drain a full queue while refills arrive; order must be preserved.
    out_ready = 1'b1;
    repeat (40) cycle();
    check("order_count", pop_log.size() >= 8, 1);
    for (int i = 0; i < 8 && i < pop_log.size(); i++)
      check("order_pc", pop_log[i].pc, 32'(i * 4));

    // Redirect while a response is outstanding.
    do_reset();
    out_ready = 1'b1; lat_min = 2; lat_max = 2;
    n = 0;
    while (!pending && n < 20) begin cycle(); n++; end
    check("reached_wait", pending, 1);
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    check("flush_out_valid", out_valid, 0);
    wait_req(20);
    check("redirect_addr", imem_addr, 32'h100);
    repeat (10) cycle();

    // Unaligned redirect target.
    redirect = 1'b1; redirect_pc = 32'h203;
    cycle();
    redirect = 1'b0;
    wait_req(20);
    check("redirect_align", imem_addr, 32'h200);
    repeat (10) cycle();

    // JAL predecode.
    do_reset();
    jal_test = 1; lat_min = 0; lat_max = 0; out_ready = 1'b1;
    repeat (30) cycle();
`ifdef IF_JAL_PREDECODE_EN
    exp_next = 32'h18; exp_pred = 1'b1;
`else
    exp_next = 32'hC;  exp_pred = 1'b0;
`endif
    check("jal_grants", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4) check("jal_next_addr", grant_log[3], exp_next);
    check("jal_pops", pop_log.size() >= 3, 1);
    if (pop_log.size() >= 3) begin
      check("jal_entry_pc", pop_log[2].pc, 32'h8);
      check("jal_entry_pred", pop_log[2].pred, exp_pred);
    end
    jal_test = 0;

    // Randomised traffic: grants, latency, back-pressure and redirects.
    do_reset();
    gnt_rand = 1; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      out_ready   = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      cycle();
    end
    redirect = 1'b0;
    check("random_progress", pop_log.size() > 20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
